// File: rtl/qisp_pkg.sv
// rtl/qisp_pkg.sv - shared types and constants for the prefetch stage
package qisp_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] DEF_RESET_PC = 16'h0000;

  typedef enum logic {
    PF_RUN  = 1'b0,
    PF_DROP = 1'b1
  } pf_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] data;
  } pf_entry_t;

endpackage

// File: rtl/pf_imem_if.sv
// rtl/pf_imem_if.sv - instruction-memory req/ack bus between prefetch and memory
interface pf_imem_if;
  import qisp_pkg::*;

  logic              imem_req;
  logic [WORD_W-1:0] imem_addr;
  logic              imem_ack;
  logic [WORD_W-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );

endinterface

// File: rtl/pf_queue.sv
// rtl/pf_queue.sv - small {pc,data} FIFO with registered head that holds when empty
module pf_queue
  import qisp_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  pf_entry_t         push_entry,
  input  logic              pop,
  input  logic              flush,
  output logic [CW-1:0]     count,
  output logic [WORD_W-1:0] head_data,
  output logic [WORD_W-1:0] head_pc
);

  localparam int PW = $clog2(DEPTH);

  pf_entry_t       mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr_nxt;
  logic [CW-1:0]   count_nxt;
  logic            pop_ok;
  pf_entry_t       head_nxt;

  assign pop_ok = pop && (count != '0);

  always_comb begin
    rd_ptr_nxt = rd_ptr;
    if (pop_ok) begin
      rd_ptr_nxt = rd_ptr + PW'(1);
    end
    count_nxt = count + CW'(push) - CW'(pop_ok);
    // A word pushed into an empty queue becomes the head without a read-back cycle.
    if (push && (rd_ptr_nxt == wr_ptr)) begin
      head_nxt = push_entry;
    end else begin
      head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      head_data <= '0;
      head_pc   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (count_nxt != '0) begin
        head_data <= head_nxt.data;
        head_pc   <= head_nxt.pc;
      end
    end
  end

endmodule

// File: rtl/pf_unit.sv
// rtl/pf_unit.sv - prefetch stage: owns pc, issues imem requests, queues words for fetch
module pf_unit
  import qisp_pkg::*;
#(
  parameter int                DEPTH    = 2,
  parameter logic [WORD_W-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  pf_imem_if.master         imem,
  input  logic              i_redirect,
  input  logic [WORD_W-1:0] i_target,
  input  logic              i_take,
  output logic              o_rdy,
  output logic [WORD_W-1:0] o_data,
  output logic [WORD_W-1:0] o_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  pf_state_t         state;
  pf_state_t         state_nxt;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pc_nxt;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_addr_nxt;
  logic [CW-1:0]     count;
  logic              req;
  logic              ack_ok;
  logic              push;
  logic              pop;
  logic              flush;
  pf_entry_t         push_entry;

  // Request is a pure function of registered state, so it cannot glitch on inputs.
  assign req            = (state == PF_DROP) || (count < DEPTH_C);
  assign imem.imem_req  = req;
  assign imem.imem_addr = (state == PF_DROP) ? req_addr : pc;
  assign ack_ok         = imem.imem_ack && req;
  assign push_entry     = '{pc: pc, data: imem.imem_data};
  assign o_rdy          = (count != '0);

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    req_addr_nxt = req_addr;
    push         = 1'b0;
    pop          = 1'b0;
    flush        = 1'b0;
    case (state)
      PF_RUN: begin
        if (i_redirect) begin
          flush  = 1'b1;
          pc_nxt = i_target;
          // Outstanding request must still complete at its original address.
          if (req && !ack_ok) begin
            state_nxt    = PF_DROP;
            req_addr_nxt = pc;
          end
        end else begin
          pop = i_take;
          if (ack_ok) begin
            push   = 1'b1;
            pc_nxt = pc + WORD_W'(1);
          end
        end
      end
      PF_DROP: begin
        if (ack_ok) begin
          state_nxt = PF_RUN;
        end
        if (i_redirect) begin
          flush  = 1'b1;
          pc_nxt = i_target;
        end
      end
      default: state_nxt = PF_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PF_RUN;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      req_addr <= req_addr_nxt;
    end
  end

  pf_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .count      (count),
    .head_data  (o_data),
    .head_pc    (o_pc)
  );

endmodule
